data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory slave for an RV32I load/store port.
// Accepts one request at a time and answers LATENCY+1 cycles later with a single-cycle response.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int LW = AW + 2;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Misalignment and illegal width codes; stores have no unsigned variants.
    function automatic logic req_err(input logic wr, input logic [1:0] a, input logic [2:0] f3);
        logic e;
        e = 1'b1;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = a[0];
            3'b010:  e = (a != 2'b00);
            3'b100:  e = wr;
            3'b101:  e = wr | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Narrow store data is replicated across the word; byte enables pick the live lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [1:0] a,
                                                input logic [2:0] f3, input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] r;
        case (f3[1:0])
            2'b00: begin
                be = 4'b0001 << a;
                d  = {4{wd[7:0]}};
            end
            2'b01: begin
                be = a[1] ? 4'b1100 : 4'b0011;
                d  = {2{wd[15:0]}};
            end
            2'b10: begin
                be = 4'b1111;
                d  = wd;
            end
            default: begin
                be = 4'b0000;
                d  = 32'd0;
            end
        endcase
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = d[8*i +: 8];
            end else begin
                r[8*i +: 8] = old[8*i +: 8];
            end
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [LW-1:0]   addr_q, addr_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_error_q, rsp_error_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            ready_s;
    logic            accept_s;
    logic            go_resp_s;
    logic            cur_wr_s;
    logic [LW-1:0]   cur_addr_s;
    logic [2:0]      cur_f3_s;
    logic [31:0]     cur_wdata_s;
    logic [AW-1:0]   cur_idx_s;
    logic            cur_err_s;
    logic [31:0]     rd_word_s;
    logic            unused_s;

    assign unused_s  = ^req_addr[31:LW];
    assign ready_s   = (state_q == S_IDLE);
    assign req_ready = ready_s;
    assign accept_s  = req_valid & ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    // With LATENCY=0 the response is built on the acceptance edge, so use the live inputs there.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_wr_s    = req_write;
            cur_addr_s  = req_addr[LW-1:0];
            cur_f3_s    = req_funct3;
            cur_wdata_s = req_wdata;
        end else begin
            cur_wr_s    = wr_q;
            cur_addr_s  = addr_q;
            cur_f3_s    = f3_q;
            cur_wdata_s = wdata_q;
        end
        cur_idx_s = cur_addr_s[LW-1:2];
        cur_err_s = req_err(cur_wr_s, cur_addr_s[1:0], cur_f3_s);
        rd_word_s = mem_q[cur_idx_s];
    end

    // Next-state, wait counter, request latch and response generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        go_resp_s   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    wr_d    = req_write;
                    addr_d  = req_addr[LW-1:0];
                    f3_d    = req_funct3;
                    wdata_d = req_wdata;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d   = S_RESP;
                        go_resp_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_RESP;
                    go_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (go_resp_s) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = cur_err_s;
            if (cur_err_s || cur_wr_s) begin
                rsp_rdata_d = 32'd0;
            end else begin
                rsp_rdata_d = load_ext(rd_word_s, cur_addr_s[1:0], cur_f3_s);
            end
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // Control, request latch and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            f3_q        <= 3'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Storage array is not reset; a store commits on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (reset && go_resp_s && cur_wr_s && !cur_err_s) begin
            mem_q[cur_idx_s] <= store_merge(rd_word_s, cur_addr_s[1:0], cur_f3_s, cur_wdata_s);
        end
    end

endmodule
